// File: rtl/uart_host_tx.sv
// Host-side 8N1 UART transmitter with a byte FIFO; drives the SoC rxd pin, LSB first, DIV clocks per bit.
// Latency: a byte pushed into an empty FIFO while idle is popped on the next edge and txd falls right after it.
// Backpressure: full is asserted at DEPTH entries; a push while full is dropped and sets the sticky ovf flag.
module uart_host_tx #(
  parameter int DIV   = 868,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     ovf,
  output logic                     txd
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [15:0]   RELOAD  = 16'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [15:0]     timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            txd_q, txd_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            ovf_q;
  logic [7:0]      mem_q [DEPTH];
  logic            push, pop, empty;

  // full/empty come from the registered level, so a push coinciding with a pop while full is still dropped
  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);
  assign push  = wr_en && !full;

  assign level = level_q;
  assign ovf   = ovf_q;
  assign txd   = txd_q;
  assign busy  = (state_q != IDLE) || !empty;

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (wr_en && full) ovf_q <= 1'b1;
    end
  end

  // Transmit state, bit timer, bit index, shift register and the registered line output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic: every bit boundary reloads the timer; STOP chains straight into START when more data waits
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = mem_q[rd_ptr_q];
          timer_d = RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (timer_q == '0) begin
          timer_d = RELOAD;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d = RELOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            sh_d  = {1'b0, sh_q[7:1]};
            idx_d = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          timer_d = RELOAD;
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // line level is a function of the next state so txd comes straight from a flop
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

endmodule
